// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter sharing one rw_queue write port among NUM_REQ producers, with credit flow control.
// Optional feature macro QWA_BURST_EN: the current owner may keep the grant for up to MAX_BURST beats.
module queue_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned QUEUE_LEN  = 3,
    parameter int unsigned MAX_BURST  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic                           credit_ret,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           q_wen,
    output logic [DATA_WIDTH-1:0]          q_data,
    output logic [$clog2(QUEUE_LEN+1)-1:0] credits,
    output logic                           stall,
    output logic                           credit_err
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CRED_W = $clog2(QUEUE_LEN + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(QUEUE_LEN);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_BURST,
        S_BLOCKED
    } state_t;

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_cfg_check
        $error("queue_write_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_last;
    logic                  r_q_wen;
    logic [DATA_WIDTH-1:0] r_q_data;
    logic [CRED_W-1:0]     r_credits;
    logic                  r_stall;
    logic                  r_credit_err;

    logic                  w_avail;
    logic                  w_grant;
    logic                  w_win_valid;
    logic                  w_rr_found;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_rr_idx;
    logic [IDX_W-1:0]      w_cand;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Round-robin search: first requester at last+1, last+2, ... modulo NUM_REQ
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDX_W'((32'(r_last) + i) % NUM_REQ);
            if (!w_rr_found && req[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

`ifdef QWA_BURST_EN
    localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);
    localparam state_t ST_GNT = S_BURST;

    logic [BCNT_W-1:0] r_bcnt;
    logic              w_others;
    logic              w_keep;

    // Owner keeps the port until it drops or has used its burst while others wait
    always_comb begin
        w_others    = |(req & ~(NUM_REQ'(1) << r_last));
        w_keep      = (r_state == S_BURST) && req[r_last] &&
                      ((r_bcnt < BCNT_LAST) || !w_others);
        w_win_valid = w_keep | w_rr_found;
        w_win       = w_keep ? r_last : w_rr_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
        end else if (w_grant && w_keep) begin
            if (r_bcnt < BCNT_LAST) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
        end else begin
            r_bcnt <= '0;
        end
    end
`else
    localparam state_t ST_GNT = S_OWN;

    always_comb begin
        w_win_valid = w_rr_found;
        w_win       = w_rr_idx;
    end
`endif

    // Select the winning requester's word
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A returning credit makes a slot usable in the same cycle, even at zero credits
    always_comb begin
        w_next  = r_state;
        gnt     = '0;
        w_avail = (r_credits != '0) | credit_ret;
        w_grant = ~rst & w_avail & w_win_valid;
        if (w_grant) begin
            gnt = NUM_REQ'(1) << w_win;
        end
        case (r_state)
            S_IDLE, S_OWN, S_BURST: begin
                if (w_grant) begin
                    w_next = ST_GNT;
                end else if (|req) begin
                    w_next = S_BLOCKED;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BLOCKED: begin
                if (w_grant) begin
                    w_next = ST_GNT;
                end else if (!(|req)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last       <= LAST_RST;
            r_q_wen      <= 1'b0;
            r_q_data     <= '0;
            r_credits    <= CRED_FULL;
            r_stall      <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_q_wen <= w_grant;
            r_stall <= (w_next == S_BLOCKED);
            if (w_grant) begin
                r_last   <= w_win;
                r_q_data <= w_wdata;
            end
            // A return that coincides with a grant cancels it; a return at full is spurious
            if (w_grant && !credit_ret) begin
                r_credits <= r_credits - CRED_W'(1);
            end else if (!w_grant && credit_ret && (r_credits != CRED_FULL)) begin
                r_credits <= r_credits + CRED_W'(1);
            end
            if (!w_grant && credit_ret && (r_credits == CRED_FULL)) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign q_wen      = r_q_wen;
    assign q_data     = r_q_data;
    assign credits    = r_credits;
    assign stall      = r_stall;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_queue_write_arbiter.sv
// Scoreboard bench for queue_write_arbiter: directed vectors push expected writes, a monitor checks q_data.
// Expected grant orders follow the QWA_BURST_EN setting of the build.
module tb_queue_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        credit_ret = 1'b0;
    logic [15:0] dat [4];
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        q_wen;
    logic [15:0] q_data;
    logic [1:0]  credits;
    logic        stall;
    logic        credit_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [3:0]  t1 [5];
    logic [3:0]  t5a [2];
    logic [3:0]  t5b;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    queue_write_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(16), .QUEUE_LEN(3), .MAX_BURST(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .credit_ret(credit_ret),
        .gnt(gnt), .q_wen(q_wen), .q_data(q_data), .credits(credits),
        .stall(stall), .credit_err(credit_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        oh2idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) oh2idx = i;
        end
    endfunction

    // Called just after a rising edge: drive, check the grant mid-cycle, log the expected write
    task automatic cyc(input logic [3:0] r, input logic cr, input logic [3:0] eg, input string nm);
        req        = r;
        credit_ret = cr;
        #3;
        check(nm, 32'(gnt), 32'(eg));
        if (eg != 4'b0000) exp_q.push_back(dat[oh2idx(eg)]);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write beat must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && q_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q_data: unexpected write 0x%0h expected none at %0t", q_data, $time);
            end else begin
                check("q_data", 32'(q_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
`ifdef QWA_BURST_EN
        t1  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
        t5a = '{4'b1000, 4'b1000};
        t5b = 4'b0010;
`else
        t1  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t5a = '{4'b1000, 4'b0010};
        t5b = 4'b1000;
`endif
        for (int i = 0; i < 4; i++) dat[i] = 16'h0000;

        // Reset values, with requests active during reset
        @(posedge clk);
        #1;
        req = 4'b1111;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_q_wen", 32'(q_wen), 32'h0);
        check("rst_credits", 32'(credits), 32'd3);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_credit_err", 32'(credit_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0000;

        // 1: all request, credit returned every cycle
        for (int i = 0; i < 4; i++) dat[i] = 16'(16'h1000 + i);
        for (int k = 0; k < 5; k++) cyc(4'b1111, 1'b1, t1[k], "t1_gnt");
        check("t1_credits", 32'(credits), 32'd3);
        check("t1_credit_err", 32'(credit_err), 32'h0);
        cyc(4'b0000, 1'b0, 4'b0000, "idle_gnt");

        // 2: single requester drains credits, stalls, resumes on a credit pulse
        dat[0] = 16'h00A1; cyc(4'b0001, 1'b0, 4'b0001, "t2_gnt1");
        check("t2_credits2", 32'(credits), 32'd2);
        dat[0] = 16'h00A2; cyc(4'b0001, 1'b0, 4'b0001, "t2_gnt2");
        check("t2_credits1", 32'(credits), 32'd1);
        dat[0] = 16'h00A3; cyc(4'b0001, 1'b0, 4'b0001, "t2_gnt3");
        check("t2_credits0", 32'(credits), 32'd0);
        check("t2_stall_pre", 32'(stall), 32'h0);
        dat[0] = 16'h00A4; cyc(4'b0001, 1'b0, 4'b0000, "t2_blk_gnt");
        check("t2_stall1", 32'(stall), 32'h1);
        cyc(4'b0001, 1'b0, 4'b0000, "t2_blk_gnt2");
        check("t2_stall2", 32'(stall), 32'h1);
        cyc(4'b0001, 1'b1, 4'b0001, "t2_resume_gnt");
        check("t2_credits_held", 32'(credits), 32'd0);
        check("t2_stall_clr", 32'(stall), 32'h0);

        // 3: zero credits with a same-cycle return still grants
        dat[2] = 16'h00C3; cyc(4'b0100, 1'b1, 4'b0100, "t3_gnt");
        check("t3_credits", 32'(credits), 32'd0);
        for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b1, 4'b0000, "t3_ret_gnt");
        check("t3_credits_full", 32'(credits), 32'd3);
        check("t3_credit_err", 32'(credit_err), 32'h0);

        // 4: spurious return at full credits is sticky
        cyc(4'b0000, 1'b1, 4'b0000, "t4_gnt");
        check("t4_credits", 32'(credits), 32'd3);
        check("t4_credit_err", 32'(credit_err), 32'h1);
        cyc(4'b0000, 1'b0, 4'b0000, "t4_idle_gnt");
        check("t4_credit_err_sticky", 32'(credit_err), 32'h1);

        // 5: reset in the middle of a stream discards the pending beat
        dat[1] = 16'h00B1; dat[3] = 16'h00B3;
        cyc(4'b1010, 1'b1, t5a[0], "t5_gnt1");
        cyc(4'b1010, 1'b1, t5a[1], "t5_gnt2");
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_q_wen", 32'(q_wen), 32'h0);
        check("t5_rst_credits", 32'(credits), 32'd3);
        check("t5_rst_credit_err", 32'(credit_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'b1010, 1'b1, 4'b0010, "t5_first_gnt");
        cyc(4'b1010, 1'b1, t5b, "t5_next_gnt");

        // 6: wrap from requester 3 to requester 0 without losing a word
        dat[3] = 16'h00D1; cyc(4'b1000, 1'b1, 4'b1000, "t6_gnt1");
        dat[0] = 16'h00D2; cyc(4'b0001, 1'b1, 4'b0001, "t6_gnt2");
        dat[3] = 16'h00D3; cyc(4'b1000, 1'b1, 4'b1000, "t6_gnt3");
        dat[0] = 16'h00D4; cyc(4'b0001, 1'b1, 4'b0001, "t6_gnt4");
        check("t6_credits", 32'(credits), 32'd3);
        cyc(4'b0000, 1'b0, 4'b0000, "drain_gnt1");
        cyc(4'b0000, 1'b0, 4'b0000, "drain_gnt2");
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
